// File: rtl/intpol2_d4_pkg.sv
// Shared helpers for the intpol2 sample FIFO: depth derivation, almost-full
// threshold and parameter legality.
package intpol2_d4_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic int unsigned afull_threshold(input int unsigned depth,
                                                  input int unsigned margin);
    return depth - margin;
  endfunction

  function automatic bit afull_margin_legal(input int unsigned depth,
                                            input int unsigned margin);
    return (margin >= 32'd1) && (margin < depth);
  endfunction

endpackage

// File: rtl/intpol2_d4_fifo_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is.
import intpol2_d4_pkg::*;

module intpol2_d4_fifo_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter bit          WRITE_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first forwarding is only wanted when reading the slot being written
  // means reading the newest sample (look-ahead read in FWFT mode).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (WRITE_FIRST && we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/intpol2_d4_sample_fifo.sv
// Synchronous sample FIFO with Empty/Afull/Full flags, occupancy and sticky
// error flags. Define INTPOL2_FIFO_FWFT_EN for first-word-fall-through reads.
import intpol2_d4_pkg::*;

module intpol2_d4_sample_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  Write_Enable,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  Read_Enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  Empty,
  output logic                  Afull,
  output logic                  Full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH_C = CW'(afull_threshold(DEPTH, AFULL_MARGIN));

  if (!afull_margin_legal(DEPTH, AFULL_MARGIN)) begin : g_bad_afull_margin
    $error("intpol2_d4_sample_fifo: AFULL_MARGIN must be in 1..DEPTH-1");
  end

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rd_go;
  logic                  wr_go;
  logic [CW-1:0]         count_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;

  // Acceptance, pointer and occupancy next-state; clear overrides traffic.
  always_comb begin
    rd_acc     = Read_Enable && !Empty;
    wr_acc     = Write_Enable && (!Full || rd_acc);
    rd_go      = rd_acc && !clear;
    wr_go      = wr_acc && !clear;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (wr_acc) wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

`ifdef INTPOL2_FIFO_FWFT_EN
  // Look-ahead read keeps the head sample in the read register; a stale
  // value is held once the FIFO drains.
  localparam bit RD_WRITE_FIRST = 1'b1;
  always_comb begin
    mem_re    = !clear && (count_nxt != '0);
    mem_raddr = rd_ptr_nxt;
  end
`else
  localparam bit RD_WRITE_FIRST = 1'b0;
  always_comb begin
    mem_re    = rd_go;
    mem_raddr = rd_ptr;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      Empty  <= 1'b1;
      Full   <= 1'b0;
      Afull  <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      Empty  <= (count_nxt == '0);
      Full   <= (count_nxt == DEPTH_C);
      Afull  <= (count_nxt >= AFULL_TH_C);
      if (clear) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (Write_Enable && !wr_acc) ovf <= 1'b1;
        if (Read_Enable && !rd_acc)  udf <= 1'b1;
      end
    end
  end

  intpol2_d4_fifo_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_FIRST (RD_WRITE_FIRST)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .we    (wr_go),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_intpol2_d4_sample_fifo.sv
// Self-checking bench for intpol2_d4_sample_fifo with a queue scoreboard.
module tb_intpol2_d4_sample_fifo;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MARGIN = 2;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          Write_Enable;
  logic [DW-1:0] wr_data;
  logic          Read_Enable;
  logic [DW-1:0] rd_data;
  logic          Empty;
  logic          Afull;
  logic          Full;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  intpol2_d4_sample_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_MARGIN (MARGIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .Write_Enable (Write_Enable),
    .wr_data      (wr_data),
    .Read_Enable  (Read_Enable),
    .rd_data      (rd_data),
    .Empty        (Empty),
    .Afull        (Afull),
    .Full         (Full),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] sb[$];
  int unsigned   m_count;
  logic          m_ovf;
  logic          m_udf;
  logic [DW-1:0] exp_rd;
  int unsigned   max_count;

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    exp_rd  = '0;
  endtask

  // Drive one cycle of stimulus and advance the scoreboard model.
  task automatic drive_cycle(input logic clr, input logic we, input logic [DW-1:0] wd,
                             input logic re);
    bit racc;
    bit wacc;
    @(negedge clk);
    clear        = clr;
    Write_Enable = we;
    wr_data      = wd;
    Read_Enable  = re;
    if (clr) begin
      model_reset();
    end else begin
      racc = re && (m_count > 0);
      wacc = we && ((m_count < DEPTH) || racc);
      if (we && !wacc) m_ovf = 1'b1;
      if (re && !racc) m_udf = 1'b1;
`ifdef INTPOL2_FIFO_FWFT_EN
      if (racc) sb.delete(0);
`else
      if (racc) exp_rd = sb.pop_front();
`endif
      if (wacc) sb.push_back(wd);
      m_count = sb.size();
`ifdef INTPOL2_FIFO_FWFT_EN
      if (m_count > 0) exp_rd = sb[0];
`endif
    end
    if (m_count > max_count) max_count = m_count;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (count !== '0 || Empty !== 1'b1 || Afull !== 1'b0 || Full !== 1'b0 ||
        ovf !== 1'b0 || udf !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d E=%b AF=%b F=%b ovf=%b udf=%b rd=%h required 0 1 0 0 0 0 0",
               count, Empty, Afull, Full, ovf, udf, rd_data);
    end
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    drive_cycle(1'b0, 1'b1, DW'(32'h200), 1'b0);
    n_checks++;
    if (count !== 5'(m_count) || m_count != 5 || rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL pre_reset_fill: count=%0d rd=%h required count=5 rd=%h", count, rd_data, exp_rd);
    end
    // Asynchronous reset mid-cycle, observed before any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (count !== '0 || Empty !== 1'b1 || Afull !== 1'b0 || Full !== 1'b0 ||
        ovf !== 1'b0 || udf !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d E=%b AF=%b F=%b ovf=%b udf=%b rd=%h required 0 1 0 0 0 0 0",
               count, Empty, Afull, Full, ovf, udf, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clear();
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 17; i++) drive_cycle(1'b0, 1'b1, DW'(32'h300 + i), 1'b0);
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (ovf !== 1'b1 || udf !== 1'b1 || count !== 5'(m_count) || rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL pre_clear: ovf=%b udf=%b count=%0d rd=%h required 1 1 %0d %h",
               ovf, udf, count, rd_data, m_count, exp_rd);
    end
    drive_cycle(1'b1, 1'b1, DW'(32'hDEAD), 1'b1);
    n_checks++;
    if (count !== '0 || Empty !== 1'b1 || Afull !== 1'b0 || Full !== 1'b0 ||
        ovf !== 1'b0 || udf !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL clear_state: count=%0d E=%b AF=%b F=%b ovf=%b udf=%b rd=%h required 0 1 0 0 0 0 0",
               count, Empty, Afull, Full, ovf, udf, rd_data);
    end
  endtask

  task automatic test_fill_drain();
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b0, 1'b1, DW'(i), 1'b0);
      n_checks++;
      if (count !== 5'(i) || Empty !== 1'b0 || Afull !== (i >= 14) || Full !== (i == 16) || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d E=%b AF=%b F=%b ovf=%b required count=%0d E=0 AF=%b F=%b ovf=0",
                 i, count, Empty, Afull, Full, ovf, i, (i >= 14), (i == 16));
      end
    end
    drive_cycle(1'b0, 1'b1, DW'(32'h11), 1'b0);
    n_checks++;
    if (ovf !== 1'b1 || count !== 5'(16) || Full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b count=%0d F=%b required ovf=1 count=16 F=1", ovf, count, Full);
    end
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (rd_data !== exp_rd || count !== 5'(m_count) || Empty !== (m_count == 0) ||
          Afull !== (m_count >= DEPTH - MARGIN) || Full !== 1'b0) begin
        n_fail++;
        $display("FAIL drain[%0d]: rd=%h count=%0d E=%b AF=%b F=%b required rd=%h count=%0d E=%b AF=%b F=0",
                 i, rd_data, count, Empty, Afull, Full, exp_rd, m_count, (m_count == 0),
                 (m_count >= DEPTH - MARGIN));
      end
    end
`ifndef INTPOL2_FIFO_FWFT_EN
    n_checks++;
    if (rd_data !== DW'(32'h10) || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_last: rd=%h E=%b required rd=00000010 E=1", rd_data, Empty);
    end
`endif
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held;
    held = exp_rd;
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (udf !== 1'b1 || rd_data !== held || count !== '0 || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: udf=%b rd=%h count=%0d E=%b required udf=1 rd=%h count=0 E=1",
               udf, rd_data, count, Empty, held);
    end
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, 1'b1, DW'(32'h55), 1'b1);
    n_checks++;
    if (count !== 5'(1) || udf !== 1'b1 || ovf !== 1'b0 || Empty !== 1'b0 || rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL empty_rw: count=%0d udf=%b ovf=%b E=%b rd=%h required count=1 udf=1 ovf=0 E=0 rd=%h",
               count, udf, ovf, Empty, rd_data, exp_rd);
    end
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (rd_data !== DW'(32'h55) || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_rw_read: rd=%h E=%b required rd=00000055 E=1", rd_data, Empty);
    end
  endtask

  task automatic test_simultaneous_full();
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, 1'b1, DW'($urandom), 1'b0);
    drive_cycle(1'b0, 1'b1, DW'(32'hF00D), 1'b1);
    n_checks++;
    if (count !== 5'(16) || ovf !== 1'b0 || Full !== 1'b1 || Afull !== 1'b1 || rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL full_rw: count=%0d ovf=%b F=%b AF=%b rd=%h required count=16 ovf=0 F=1 AF=1 rd=%h",
               count, ovf, Full, Afull, rd_data, exp_rd);
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (rd_data !== exp_rd || count !== 5'(m_count)) begin
        n_fail++;
        $display("FAIL full_rw_drain[%0d]: rd=%h count=%0d required rd=%h count=%0d",
                 i, rd_data, count, exp_rd, m_count);
      end
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    max_count = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, 1'b1, DW'($urandom), 1'b0);
      drive_cycle(1'b0, 1'b1, DW'($urandom), 1'b1);
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (rd_data !== exp_rd || count !== 5'(m_count) || udf !== 1'b0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap[%0d]: rd=%h count=%0d udf=%b ovf=%b required rd=%h count=%0d udf=0 ovf=0",
                 i, rd_data, count, udf, ovf, exp_rd, m_count);
      end
    end
    n_checks++;
    if (max_count > 2 || count !== '0 || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_end: max_count=%0d count=%0d E=%b required max<=2 count=0 E=1",
               max_count, count, Empty);
    end
  endtask

  task automatic test_first_word();
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, 1'b1, DW'(32'hA5), 1'b0);
    n_checks++;
`ifdef INTPOL2_FIFO_FWFT_EN
    if (rd_data !== DW'(32'hA5) || Empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_head: rd=%h E=%b required rd=000000a5 E=0", rd_data, Empty);
    end
`else
    if (rd_data !== '0 || Empty !== 1'b0) begin
      n_fail++;
      $display("FAIL std_no_read: rd=%h E=%b required rd=00000000 E=0", rd_data, Empty);
    end
`endif
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (rd_data !== DW'(32'hA5) || Empty !== 1'b1 || rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL first_word_read: rd=%h E=%b required rd=000000a5 E=1", rd_data, Empty);
    end
  endtask

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
    wr_data      = '0;
    max_count    = 0;
    test_reset();
    test_clear();
    test_fill_drain();
    test_underflow();
    test_simultaneous_full();
    test_wrap();
    test_first_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intpol2_d4_sample_fifo.md
# intpol2_d4_sample_fifo

Synchronous sample FIFO that buffers data between the interpolator and its neighbours. One instance sits upstream of the interpolator datapath and drives its `Empty` input. A second instance sits downstream, is written via the controlpath's `Write_Enable`, and drives its `Afull` input. It provides Empty, Almost-full and Full flags, an occupancy count, and sticky overflow/underflow error flags. A synchronous `clear` flushes it between runs.

## Interface
- `DATA_WIDTH`, 32: sample width in bits.
- `ADDR_WIDTH`, 4: log2 of capacity; DEPTH = 2**ADDR_WIDTH entries.
- `AFULL_MARGIN`, 2: Afull asserts when count >= DEPTH - AFULL_MARGIN; legal range 1..DEPTH-1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous flush of contents and error flags.
- `Write_Enable`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  write sample.
- `Read_Enable`  in  1  read request.
- `rd_data`  out  DATA_WIDTH  read sample.
- `Empty`  out  1  no readable sample.
- `Afull`  out  1  almost full.
- `Full`  out  1  count == DEPTH.
- `count`  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- `ovf`  out  1  sticky: a write was rejected.
- `udf`  out  1  sticky: a read was rejected.

## Operation
- Read accepted (rd_acc) iff `Read_Enable` && !`Empty`.
- Write accepted (wr_acc) iff `Write_Enable` && (!`Full` || rd_acc). A simultaneous read frees the slot, so a write to a full FIFO is accepted when a read is also accepted.
- Rejected write sets `ovf`; the FIFO state is unchanged. Rejected read sets `udf`; `rd_data` holds its value.
- Pointers: ADDR_WIDTH-bit write/read pointers, wrapping modulo DEPTH. `count` updates by +1, -1 or 0 for wr_acc/rd_acc combinations; it never exceeds DEPTH and never goes below 0.
- Flags are registered and derived from next-state `count`: `Empty` = (count==0), `Full` = (count==DEPTH), `Afull` = (count >= DEPTH-AFULL_MARGIN).
- `clear` takes priority over same-cycle reads and writes, which are ignored (no ovf/udf set). Next cycle the FIFO is in the reset state.
- `rst` or `clear` state: `count`=0, `Empty`=1, `Full`=0, `Afull`=0, `ovf`=0, `udf`=0, `rd_data`=0, pointers=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored samples immediately and asynchronously.

## Timing
- Write at edge N: `count`/`Empty`/`Afull`/`Full` reflect it at N+1.
- Non-FWFT (macro absent): rd_acc at edge M puts the sample in `rd_data` after edge M (valid in cycle M+1). It holds until the next rd_acc.
- Minimum write-to-read latency: sample written at edge N, read at edge N+1, data valid in cycle N+2.
- Full throughput: one write and one read per cycle sustained at any occupancy 1..DEPTH-1.

## Configuration
- `INTPOL2_FIFO_FWFT_EN` defined: first-word-fall-through. The head sample appears on `rd_data` while `Empty`=0. rd_acc pops it, and the next head (or hold, if the FIFO becomes empty) appears in the following cycle. A write to an empty FIFO at edge N makes `rd_data` valid with `Empty`=0 in cycle N+1. `count` includes the head sample.
- Undefined: standard mode as above; `rd_data` updates only on rd_acc.

## Structure
- Shared package `intpol2_d4_pkg`: DEPTH derivation function, AFULL threshold function, parameter legality checks (elaboration-time assertion on AFULL_MARGIN).
- Sub-module `intpol2_d4_fifo_mem`: simple dual-port RAM, DEPTH x DATA_WIDTH, one write port and one registered read port. No reset on the array.
- Top level holds pointers, count, flag registers, error flags and the FWFT head register.

## Test plan
- Reset/clear: drive `rst`=1 mid-stream with count=5 -> immediately count=0, Empty=1, Afull=0, Full=0, ovf=udf=0. Repeat with `clear` -> same result one edge later.
- Fill/drain: write 0x1..0x10 with DEPTH=16, AFULL_MARGIN=2 -> Afull rises after the 14th write, Full after the 16th. Then read 16 -> data 0x1..0x10 in order, Empty=1 after the last read.
- Overflow/underflow: 17th write while full with no read -> ovf=1, count stays 16. Read while empty -> udf=1, rd_data unchanged.
- Simultaneous ops: at full, Write_Enable=Read_Enable=1 -> both accepted, count=16, ovf=0. At empty, both asserted -> write accepted, udf=1, count=1.
- Wrap-around: 40 interleaved write/read pairs with random data -> order preserved across pointer wrap, count never exceeds 2.
- FWFT build: write 0xA5 at edge N into an empty FIFO -> rd_data=0xA5 and Empty=0 in cycle N+1 with no Read_Enable. Non-FWFT build -> rd_data=0xA5 only after a read edge.
